// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - request size encodings carried on req_size
//   - responder FSM state enum
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: synchronous single-port RAM, 2**ADDR_W words of 32 bits.
// Ports:
//   clk   - clock
//   en    - port enable; a read (and any enabled byte writes) happen on this edge
//   be    - per-byte write enables, bit n covers bits [8n+7:8n]
//   addr  - word address
//   wdata - write data, already steered to its byte lanes
//   rdata - registered read data (read-first); holds while en is low
// Contents are never reset.
module dmem_bank #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // One byte-wide array per lane keeps each lane a simple RAM with its own write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] q_reg;

    always_ff @(posedge clk) begin
      if (en) begin
        if (be[gi]) begin
          mem[addr] <= wdata[gi*8 +: 8];
        end
        q_reg <= mem[addr];
      end
    end

    assign rdata[gi*8 +: 8] = q_reg;
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: CPU data-memory responder with fixed wait states.
// Ports:
//   clk, rst                - clock; asynchronous active-high reset
//   req_valid/req_ready     - request handshake (ready only in IDLE)
//   req_we, req_size        - store/load, 0=byte 1=half 2=word 3=illegal
//   req_addr, req_wdata     - byte address, right-aligned store data
//   resp_valid/resp_ready   - response handshake (valid only in RESP)
//   resp_rdata, resp_err    - zero-extended load data; error flag
// Legal accesses spend max(WAIT_CYCLES,1) cycles in WAIT; the RAM is
// touched only on the WAIT->RESP edge, so a store commits exactly once and a
// reset before that edge leaves memory untouched. Errors skip WAIT.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  // Counter preload: the last WAIT cycle is the one where the counter reads 0.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  // Address bits above the memory's byte range must be zero.
  localparam logic [31:0] HI_MASK = ~((32'd1 << (ADDR_W + 2)) - 32'd1);

  state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  logic              we_reg;
  logic [1:0]        size_reg;
  logic [1:0]        off_reg;
  logic [ADDR_W-1:0] word_reg;
  logic [31:0]       wdata_reg;
  logic              err_reg;

  logic        accept;
  logic        req_err;
  logic        mem_en;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] bank_q;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign req_ready = (state_reg == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  assign req_err = (req_size == SZ_ILLEGAL)
                 | ((req_size == SZ_HALF) & req_addr[0])
                 | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                 | ((req_addr & HI_MASK) != 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      size_reg  <= SZ_BYTE;
      off_reg   <= 2'd0;
      word_reg  <= '0;
      wdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg    <= req_we;
        size_reg  <= req_size;
        off_reg   <= req_addr[1:0];
        word_reg  <= req_addr[ADDR_W+1:2];
        wdata_reg <= req_wdata;
        err_reg   <= req_err;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mem_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_next = RESP;
            cnt_next   = 4'd0;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
          mem_en     = !rst;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Store lane steering: replicate the right-aligned data so every candidate
  // lane carries it, and let the byte enables pick the addressed one.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = wdata_reg;
    case (size_reg)
      SZ_BYTE: begin
        lane_be    = 4'b0001 << off_reg;
        lane_wdata = {4{wdata_reg[7:0]}};
      end
      SZ_HALF: begin
        lane_be    = off_reg[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_reg[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_reg;
      end
    endcase
  end

  dmem_bank #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk   (clk),
    .en    (mem_en),
    .be    (lane_be & {4{we_reg}}),
    .addr  (word_reg),
    .wdata (lane_wdata),
    .rdata (bank_q)
  );

  // Load extraction from the registered RAM word; it is captured only on the
  // WAIT->RESP edge, so it stays stable for the whole RESP phase.
  always_comb begin
    shifted   = bank_q >> {off_reg, 3'b000};
    load_data = shifted;
    case (size_reg)
      SZ_BYTE: load_data = {24'd0, shifted[7:0]};
      SZ_HALF: load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign resp_valid = (state_reg == RESP);
  assign resp_err   = (state_reg == RESP) && err_reg;
  assign resp_rdata = ((state_reg == RESP) && !err_reg && !we_reg) ? load_data : 32'd0;

endmodule
